// File: rtl/stream_pkg.sv
// Shared definitions for the packet FIFO: default beat width and the beat payload layout.
package stream_pkg;

  localparam int unsigned STREAM_DATA_W = 8;

  typedef struct packed {
    logic                     last;
    logic [STREAM_DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/stream_pkt_fifo_if.sv
// Upstream/downstream stream handshake plus occupancy status for stream_pkt_fifo.
interface stream_pkt_fifo_if #(
  parameter int unsigned DATA_W = stream_pkg::STREAM_DATA_W,
  parameter int unsigned DEPTH  = 16
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [CW-1:0]     count;
  logic [CW-1:0]     pkt_count;

  // FIFO side
  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last, count, pkt_count
  );

  // Producer/consumer side
  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last, count, pkt_count
  );

endinterface

// File: rtl/stream_fifo_mem.sv
// Beat storage: synchronous write, asynchronous read, contents never reset.
module stream_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_W:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_W:0]            o_rdata
);

  logic [DATA_W:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_pkt_fifo.sv
// Packet-aware stream FIFO with first-word fall-through; store-and-forward or cut-through release.
module stream_pkt_fifo
  import stream_pkg::*;
#(
  parameter int unsigned DATA_W    = STREAM_DATA_W,
  parameter int unsigned DEPTH     = 16,
  parameter bit          STORE_FWD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  stream_pkt_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_pkt_fifo: DEPTH must be a power of two and at least 4");
  end

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_pkt_count;
  logic            r_force_rel;
  logic            r_rdy_en;
  logic            w_full;
  logic            w_s_ready;
  logic            w_m_valid;
  logic            w_wr;
  logic            w_rd;
  logic            w_pkt_in;
  logic            w_pkt_out;
  logic            w_oversize;
  logic [DATA_W:0] w_rd_beat;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_s_ready  = r_rdy_en & ~w_full;
  // Store-and-forward holds the head until a whole packet is present, or an oversize packet forces release
  assign w_m_valid  = (r_count != '0) & (~STORE_FWD | (r_pkt_count != '0) | r_force_rel);
  assign w_wr       = bus.s_valid & w_s_ready;
  assign w_rd       = w_m_valid & bus.m_ready;
  assign w_pkt_in   = w_wr & bus.s_last;
  assign w_pkt_out  = w_rd & w_rd_beat[DATA_W];
  assign w_oversize = w_full & (r_pkt_count == '0);

  stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata ({bus.s_last, bus.s_data}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_beat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pkt_count <= '0;
    end else begin
      case ({w_pkt_in, w_pkt_out})
        2'b10:   r_pkt_count <= r_pkt_count + CW'(1);
        2'b01:   r_pkt_count <= r_pkt_count - CW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // Reading the oversize packet's last beat ends the forced release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_force_rel <= 1'b0;
    end else if (w_pkt_out) begin
      r_force_rel <= 1'b0;
    end else if (w_oversize) begin
      r_force_rel <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.m_valid   = w_m_valid;
  assign bus.m_data    = w_m_valid ? w_rd_beat[DATA_W-1:0] : '0;
  assign bus.m_last    = w_m_valid & w_rd_beat[DATA_W];
  assign bus.count     = r_count;
  assign bus.pkt_count = r_pkt_count;

endmodule

// File: doc/stream_pkt_fifo.md
STREAM_PKT_FIFO -- requirements
Module: stream_pkt_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 8, SHALL set the beat data width.
REQ-003 Parameter DEPTH, default 16, SHALL set the entry count; it SHALL be a power of two and at least 4.
REQ-004 Parameter STORE_FWD, default 1, SHALL select the mode: 1 = store-and-forward, 0 = cut-through.
REQ-005 Ports SHALL be as follows (AW = log2(DEPTH)):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- s_data  in  DATA_W  upstream data (fed by the 2:1 stream mux m_* outputs)
- s_valid  in  1  upstream beat valid
- s_ready  out  1  FIFO can accept a beat
- s_last  in  1  final beat of packet
- m_data  out  DATA_W  head-entry data
- m_valid  out  1  head beat presentable
- m_ready  in  1  downstream accepts
- m_last  out  1  head-entry last flag
- count  out  AW+1  entries held
- pkt_count  out  AW+1  complete packets held

Function
REQ-006 A write SHALL occur on a rising edge where s_valid=1 and s_ready=1; it stores {s_last, s_data} at wr_ptr, and wr_ptr SHALL then increment modulo DEPTH.
REQ-007 A read SHALL occur on a rising edge where m_valid=1 and m_ready=1; rd_ptr SHALL then increment modulo DEPTH.
REQ-008 s_ready SHALL be 1 exactly when count<DEPTH and the ready-enable flop is set; it SHALL NOT depend on m_ready, so there is no pass-through when full.
REQ-009 m_data and m_last SHALL be read combinationally from the entry at rd_ptr (first-word fall-through); both SHALL be 0 whenever m_valid=0.
REQ-010 count SHALL increment on write-only, decrement on read-only, and hold on a simultaneous read and write.
REQ-011 pkt_count SHALL increment on a write with s_last=1 and decrement on a read with m_last=1; when both occur together it SHALL hold.
REQ-012 With STORE_FWD=0, m_valid SHALL equal (count>0).
REQ-013 With STORE_FWD=1, m_valid SHALL equal (count>0) AND (pkt_count>0 OR force_rel).
REQ-014 force_rel is an internal flop. It SHALL set on an edge where count==DEPTH and pkt_count==0, which is an oversize packet. It SHALL clear on a read with m_last=1. This prevents deadlock.
REQ-015 Latency, cut-through: a beat written at edge N SHALL appear on m_* in the cycle after edge N.
REQ-016 Latency, store-and-forward: m_valid SHALL rise in the cycle after the edge that writes the packet's s_last beat.
REQ-017 s_valid, s_data and s_last SHALL be ignored while s_ready=0. m_valid, once asserted, SHALL stay asserted with m_data and m_last stable until the beat is read.
REQ-018 count SHALL never exceed DEPTH or go below 0; no write SHALL occur when full and no read SHALL occur when empty.

Reset
REQ-019 While reset=0, all of the following SHALL hold asynchronously: wr_ptr, rd_ptr, count, pkt_count and force_rel = 0; m_valid=0, m_data=0, m_last=0; s_ready=0.
REQ-020 The ready-enable flop SHALL set on the first rising edge after reset deasserts, so s_ready=1 from the following cycle.
REQ-021 Storage RAM contents SHALL NOT be reset.
REQ-022 Reset asserted mid-packet SHALL discard all held beats and partial packets, with no residual m_valid.

Structure
REQ-023 Shared package stream_pkg SHALL hold the DATA_W default and the beat struct {last, data}; the clog2 width constant SHALL be derived from DEPTH.
REQ-024 Storage SHALL be a sub-module stream_fifo_mem: DEPTH x (DATA_W+1), synchronous write, asynchronous read.
REQ-025 Pointers, counters, force_rel and handshake logic SHALL reside in stream_pkt_fifo.

Verification
REQ-026 Cut-through, m_ready=1: write 8'hA1, 8'hB2, 8'hC3 (last) -> identical order, m_last only on C3, one-cycle latency, count back to 0.
REQ-027 Store-and-forward: write a 5-beat packet with m_ready=1 -> m_valid stays 0 until the cycle after beat 5 is written, then 5 beats are delivered back to back and pkt_count goes 1->0.
REQ-028 Full: m_ready=0, drive 20 beats with no last -> s_ready drops after 16 writes, count=16, and force_rel makes m_valid=1 (DEPTH=16, STORE_FWD=1).
REQ-029 Simultaneous read and write at count=7, including a last beat in and out -> count stays 7 and pkt_count is unchanged.
REQ-030 Pointer wrap: 40 single-beat packets with random m_ready -> scoreboard matches with no loss or duplication.
REQ-031 Reset mid-packet: reset low for one cycle with count=9 -> m_valid=0, count=0, pkt_count=0, s_ready=0, then s_ready=1 one cycle after release.
